// File: rtl/dsp48_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the DSP48 slave port.
// Optional slave-ack watchdog enabled by defining DSP48_ARB_TIMEOUT_EN.
module dsp48_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hBADC_0FFE
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o,
  output logic        timeout_flag_o,
  input  logic        timeout_clr_i
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state;
  logic   last;
  logic   own0, own1;
  logic   own_stb;
  logic   leaving;
  logic   force_ack;
  logic   ack;
  logic [31:0] rdata;

  // Ties go to the master that was not served last; grants persist for the whole CYC.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= StIdle;
      last  <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= StOwn0;
          end else if (m1_cyc_i) begin
            state <= StOwn1;
          end
        end
        StOwn0: begin
          if (!m0_cyc_i) begin
            last  <= 1'b0;
            state <= m1_cyc_i ? StOwn1 : StIdle;
          end
        end
        StOwn1: begin
          if (!m1_cyc_i) begin
            last  <= 1'b1;
            state <= m0_cyc_i ? StOwn0 : StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign own0    = (state == StOwn0);
  assign own1    = (state == StOwn1);
  assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign leaving = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);
  assign grant_o = {own1, own0};

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    unique case (state)
      StOwn0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~force_ack;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      StOwn1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~force_ack;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign ack      = s_ack_i | force_ack;
  assign rdata    = force_ack ? TIMEOUT_DATA : s_dat_i;
  assign m0_ack_o = own0 & ack;
  assign m1_ack_o = own1 & ack;
  assign m0_dat_o = own0 ? rdata : 32'h0;
  assign m1_dat_o = own1 ? rdata : 32'h0;
  assign m0_err_o = own0 & force_ack;
  assign m1_err_o = own1 & force_ack;

`ifdef DSP48_ARB_TIMEOUT_EN
  localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_count;
  logic        flag;

  // The raw owner strobe is used here so force does not feed back through s_stb_o.
  assign force_ack = (wd_count == WdLast) & own_stb & ~s_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wd_count <= 16'h0;
      flag     <= 1'b0;
    end else begin
      if (s_ack_i || !own_stb || leaving || force_ack) begin
        wd_count <= 16'h0;
      end else begin
        wd_count <= wd_count + 16'h1;
      end
      if (force_ack) begin
        flag <= 1'b1;
      end else if (timeout_clr_i) begin
        flag <= 1'b0;
      end
    end
  end

  assign timeout_flag_o = flag;
`else
  logic unused_wd;

  assign force_ack      = 1'b0;
  assign timeout_flag_o = 1'b0;
  assign unused_wd      = timeout_clr_i ^ own_stb ^ leaving;
`endif

endmodule

// File: tb/tb_dsp48_wb_arbiter.sv
// Directed bench for dsp48_wb_arbiter: reset, single master, round-robin,
// burst hold and watchdog behaviour (both with and without DSP48_ARB_TIMEOUT_EN).
module tb_dsp48_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack;
  logic [1:0]  grant;
  logic        tflag, tclr;
  logic        slave_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp48_wb_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hBADC_0FFE)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .m0_cyc_i       (m0_cyc),
    .m0_stb_i       (m0_stb),
    .m0_we_i        (m0_we),
    .m0_sel_i       (m0_sel),
    .m0_adr_i       (m0_adr),
    .m0_dat_i       (m0_dat),
    .m0_ack_o       (m0_ack),
    .m0_dat_o       (m0_rdat),
    .m0_err_o       (m0_err),
    .m1_cyc_i       (m1_cyc),
    .m1_stb_i       (m1_stb),
    .m1_we_i        (m1_we),
    .m1_sel_i       (m1_sel),
    .m1_adr_i       (m1_adr),
    .m1_dat_i       (m1_dat),
    .m1_ack_o       (m1_ack),
    .m1_dat_o       (m1_rdat),
    .m1_err_o       (m1_err),
    .s_cyc_o        (s_cyc),
    .s_stb_o        (s_stb),
    .s_we_o         (s_we),
    .s_sel_o        (s_sel),
    .s_adr_o        (s_adr),
    .s_dat_o        (s_wdat),
    .s_ack_i        (s_ack),
    .s_dat_i        (s_rdat),
    .grant_o        (grant),
    .timeout_flag_o (tflag),
    .timeout_clr_i  (tclr)
  );

  // Slave stand-in: one-cycle registered ack, read data derived from the address.
  assign s_rdat = s_adr ^ 32'hA5A5_A5A5;
  always_ff @(posedge clk) begin
    if (!rst_n) s_ack <= 1'b0;
    else        s_ack <= slave_en & s_cyc & s_stb & ~s_ack;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_xfer(input int n, input logic [31:0] adr);
    logic got;
    got = 1'b0;
    if (n == 0) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = adr;
    end else begin
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_sel = 4'hF; m1_adr = adr;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        check_eq($sformatf("rr_dat%0d", n), (n == 0) ? m0_rdat : m1_rdat,
                 adr ^ 32'hA5A5_A5A5);
      end
    end
    check_eq($sformatf("rr_ack_seen%0d", n), {31'b0, got}, 32'd1);
    tick();
    if (n == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
    else        begin m1_cyc = 1'b0; m1_stb = 1'b0; end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] gq[$];
    logic [1:0] prev;
    logic       gap, held_ok, got, any_ack, any_err, any_flag;
    int         acks;

    rst_n = 1'b0; slave_en = 1'b1; tclr = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'h3;
    m0_adr = 32'h1111_0000; m0_dat = 32'hAAAA_5555;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hC;
    m1_adr = 32'h2222_0000; m1_dat = 32'h5555_AAAA;

    // Reset held for three edges with both masters requesting
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", {30'b0, grant}, 32'd0);
    check_eq("rst_s_ctl", {25'b0, s_cyc, s_stb, s_we, s_sel}, 32'd0);
    check_eq("rst_s_adr", s_adr, 32'd0);
    check_eq("rst_s_dat", s_wdat, 32'd0);
    check_eq("rst_m_flags", {27'b0, m0_ack, m1_ack, m0_err, m1_err, tflag}, 32'd0);
    check_eq("rst_m_rdat", m0_rdat | m1_rdat, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_idle", {30'b0, grant}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("rst_first_grant", {30'b0, grant}, 32'd1);
    check_eq("rst_first_adr", s_adr, 32'h1111_0000);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    // Single write from master 1
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
    m1_adr = 32'h3000_0004; m1_dat = 32'h1234_5678;
    @(negedge clk);
    check_eq("sm_pre_grant", {30'b0, grant}, 32'd0);
    check_eq("sm_pre_scyc", {31'b0, s_cyc}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("sm_grant", {30'b0, grant}, 32'd2);
    check_eq("sm_s_ctl", {25'b0, s_cyc, s_stb, s_we, s_sel}, 32'h7F);
    check_eq("sm_s_adr", s_adr, 32'h3000_0004);
    check_eq("sm_s_dat", s_wdat, 32'h1234_5678);
    check_eq("sm_ack_early", {31'b0, m1_ack}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("sm_ack", {30'b0, m1_ack, s_ack}, 32'd3);
    check_eq("sm_m0_quiet", {30'b0, m0_ack, m0_err}, 32'd0);
    check_eq("sm_rdat", m1_rdat, 32'h95A5_A5A1);
    check_eq("sm_m0_rdat", m0_rdat, 32'd0);
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    // Round-robin: four single reads per master, both always requesting
    gq.delete(); prev = 2'b00; gap = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) m_xfer(0, 32'h1000_0100 + 32'(i * 4));
      end
      begin
        for (int i = 0; i < 4; i++) m_xfer(1, 32'h2000_0100 + 32'(i * 4));
      end
      begin
        repeat (80) begin
          @(negedge clk);
          if (grant != prev) begin
            if (grant != 2'b00) gq.push_back(grant);
            else if (gq.size() > 0 && gq.size() < 8) gap = 1'b1;
            prev = grant;
          end
        end
      end
    join
    check_eq("rr_grant_count", gq.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("rr_grant%0d", i), (i < gq.size()) ? {30'b0, gq[i]} : 32'd0,
               (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    check_eq("rr_no_idle_gap", {31'b0, gap}, 32'd0);

    // Burst hold: m0 keeps CYC for five strobes while m1 waits
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h1000_0000;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h2000_0008;
    acks = 0; held_ok = 1'b1;
    for (int i = 0; i < 40 && acks < 5; i++) begin
      @(negedge clk);
      if (grant != 2'b01) held_ok = 1'b0;
      if (m0_ack) acks++;
    end
    check_eq("bh_acks", acks, 32'd5);
    check_eq("bh_held", {31'b0, held_ok}, 32'd1);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    check_eq("bh_still_m0", {30'b0, grant}, 32'd1);
    check_eq("bh_m1_wait", {31'b0, m1_ack}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("bh_handover", {30'b0, grant}, 32'd2);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (m1_ack) begin
        got = 1'b1;
        check_eq("bh_m1_rdat", m1_rdat, 32'h85A5_A5AD);
      end else begin
        @(negedge clk);
      end
    end
    check_eq("bh_m1_ack", {31'b0, got}, 32'd1);
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick(); tick();

    // Hung slave
    slave_en = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h1000_0040;
    tick();
`ifdef DSP48_ARB_TIMEOUT_EN
    any_ack = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) begin
        any_ack = any_ack | m0_ack | m0_err;
        tick();
      end
    end
    check_eq("to_no_early_ack", {31'b0, any_ack}, 32'd0);
    check_eq("to_ack_err", {30'b0, m0_ack, m0_err}, 32'd3);
    check_eq("to_rdat", m0_rdat, 32'hBADC_0FFE);
    check_eq("to_s_stb_cut", {31'b0, s_stb}, 32'd0);
    check_eq("to_flag_pre", {31'b0, tflag}, 32'd0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    check_eq("to_flag_set", {31'b0, tflag}, 32'd1);
    check_eq("to_err_pulse", {31'b0, m0_err}, 32'd0);
    tick();
    tclr = 1'b1;
    tick();
    tclr = 1'b0;
    @(negedge clk);
    check_eq("to_flag_clr", {31'b0, tflag}, 32'd0);
`else
    any_ack = 1'b0; any_err = 1'b0; any_flag = 1'b0;
    repeat (300) begin
      @(negedge clk);
      any_ack  = any_ack | m0_ack;
      any_err  = any_err | m0_err;
      any_flag = any_flag | tflag;
    end
    check_eq("nto_no_ack", {31'b0, any_ack}, 32'd0);
    check_eq("nto_no_err", {31'b0, any_err}, 32'd0);
    check_eq("nto_no_flag", {31'b0, any_flag}, 32'd0);
    check_eq("nto_still_owner", {30'b0, grant}, 32'd1);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
`endif
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp48_wb_arbiter.md
# dsp48_wb_arbiter

Two-master Wishbone arbiter that shares the single DSP48 slave port between the management SoC bus (master 0) and a second requester (master 1, e.g. an LA- or IO-driven command sequencer). It sits between the user-project Wishbone pins/sequencer and the DSP48 instance. Grants are round-robin and held for a whole bus cycle (CYC high), so block transfers are never interleaved. An optional watchdog terminates transfers the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles a slave STB may stay un-acked before forced termination (1..65535).
- TIMEOUT_DATA, 32'hBADC_0FFE: read data returned on a forced termination.

Ports (N = 0,1; each mN_ line is one port per master):
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- mN_cyc_i  in  1  master N bus-cycle request.
- mN_stb_i  in  1  master N strobe.
- mN_we_i  in  1  master N write enable.
- mN_sel_i  in  4  master N byte selects.
- mN_adr_i  in  32  master N address.
- mN_dat_i  in  32  master N write data.
- mN_ack_o  out  1  acknowledge to master N.
- mN_dat_o  out  32  read data to master N.
- mN_err_o  out  1  one-cycle pulse with ack on forced termination.
- s_cyc_o, s_stb_o, s_we_o  out  1  to DSP48.
- s_sel_o  out  4; s_adr_o, s_dat_o  out  32  to DSP48.
- s_ack_i  in  1; s_dat_i  in  32  from DSP48.
- grant_o  out  2  one-hot current owner (00 = none).
- timeout_flag_o  out  1  sticky: a forced termination occurred.
- timeout_clr_i  in  1  clears timeout_flag_o.

## Operation
- FSM states: IDLE, OWN0, OWN1; state and last-served pointer `last` are registered.
- IDLE: if exactly one mN_cyc_i high -> OWNN. If both high -> grant the master != `last`. Else stay.
- OWNN: stay while mN_cyc_i high. When mN_cyc_i low: if the other master's cyc is high -> OWN(other) directly (no bubble), else -> IDLE. `last` <= N on leaving OWNN.
- Slave mux: in OWNN, s_* driven from master N; s_cyc_o = mN_cyc_i, s_stb_o = mN_stb_i & ~force. In IDLE, s_cyc_o = s_stb_o = 0, other s_* = 0.
- Return path (combinational): owner gets mN_ack_o = s_ack_i | force, mN_dat_o = force ? TIMEOUT_DATA : s_dat_i. Non-owner gets ack 0, dat 0, err 0.
- Watchdog counter: 16 bits, cleared when s_ack_i, ~s_stb_o, or a state change. Increments while s_stb_o & ~s_ack_i. force = (count == TIMEOUT_CYCLES-1) & s_stb_o & ~s_ack_i. On force: counter clears, mN_err_o = 1 for that cycle, timeout_flag_o set next edge.
- timeout_flag_o: set has priority over timeout_clr_i in the same cycle.
- Reset (wb_rst_ni low at an edge): state IDLE, `last` = 1 (master 0 wins the first tie), counter 0, timeout_flag_o 0. All outputs: 0. Mid-transfer reset aborts the cycle silently, with no ack.

## Timing
- Grant latency: cyc rising at edge k is seen -> state OWNN after edge k; slave sees s_cyc_o/s_stb_o in cycle k+1.
- Ack is passed through with zero added latency. Single-transfer master latency = 1 + DSP48 latency.
- Handover: owner drops cyc in cycle j -> other master owns bus in cycle j+1.
- Forced ack is asserted in the cycle where count = TIMEOUT_CYCLES-1, i.e. the TIMEOUT_CYCLES-th un-acked STB cycle.

## Configuration
- DSP48_ARB_TIMEOUT_EN defined: watchdog, mN_err_o, and timeout_flag_o are active as above.
- Not defined: no counter is built, force is constant 0, mN_err_o and timeout_flag_o are tied 0, and timeout_clr_i is ignored. A hung slave stalls its owner indefinitely.

## Test plan
- Reset: hold wb_rst_ni=0 for 3 cycles with both cyc high -> all outputs 0, grant_o=00. After release, grant_o=01 in the next cycle.
- Single master: m1 writes 32'h1234_5678 to adr 32'h3000_0004 -> s_* mirror m1 from cycle k+1. m1_ack_o equals s_ack_i. m0_ack_o stays 0.
- Round-robin: both masters hold cyc for 4 back-to-back single transfers each -> grant sequence 01,10,01,10 with no IDLE cycle between owners.
- Burst hold: m0 keeps cyc for 5 strobes while m1 requests -> m1 is not granted until the cycle after m0_cyc_i falls.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never acks -> on the 8th STB cycle m0_ack_o=1, m0_err_o=1, m0_dat_o=32'hBADC_0FFE. timeout_flag_o=1 the next cycle. timeout_clr_i pulse -> flag 0.
- Timeout (macro off): same stimulus for 300 cycles -> no ack, err 0, flag 0.
